// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode, condition, field and state definitions shared by the CPU sequencer
package cpu_pkg;

    localparam logic [3:0] OP_ALU_MAX = 4'h9;
    localparam logic [3:0] OP_MOV     = 4'hA;
    localparam logic [3:0] OP_LDR     = 4'hB;
    localparam logic [3:0] OP_STR     = 4'hC;
    localparam logic [3:0] OP_B       = 4'hD;
    localparam logic [3:0] OP_NOP     = 4'hE;
    localparam logic [3:0] OP_HLT     = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Instruction field positions (least significant bit of each field)
    localparam int COND_LSB   = 28;
    localparam int OPCODE_LSB = 24;
    localparam int S_BIT      = 23;
    localparam int RD_LSB     = 19;
    localparam int RS2_LSB    = 15;
    localparam int RS1_LSB    = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int IMM_LSB    = 3;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

endpackage

// File: rtl/cpu_cond_eval.sv
// rtl/cpu_cond_eval.sv - ARM-style condition code evaluation against the {N,Z,C,V} flags
module cpu_cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute controller driving memory, register bank and ALU
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        rf_raddr1,
    output logic [3:0]        rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    output logic [15:0]       alu_imm,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        flags,
    output logic              halted,
    output logic [31:0]       retired
);

    state_t              state;
    logic [31:IMM_LSB]   instr;
    logic [DATA_W-1:0]   load_data;
    logic                cond_pass;
    logic [3:0]          opcode;
    logic [15:0]         imm16;
    logic                is_alu;
    logic                exec_write;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   br_target;

    assign opcode     = instr[OPCODE_LSB +: 4];
    assign imm16      = instr[IMM_LSB +: 16];
    assign is_alu     = (opcode <= OP_ALU_MAX);
    assign exec_write = (state == ST_EXEC) && (is_alu || opcode == OP_MOV);
    assign pc_inc     = pc + ADDR_W'(1);
    // pc already points past the branch, so the offset is relative to the next word
    assign br_target  = pc + ADDR_W'(signed'(imm16));

    cpu_cond_eval u_cond_eval (
        .cond  (instr[COND_LSB +: 4]),
        .flags (flags),
        .pass  (cond_pass)
    );

    assign rf_raddr1 = instr[RS1_LSB +: 4];
    assign rf_raddr2 = instr[RS2_LSB +: 4];
    assign rf_waddr  = instr[RD_LSB +: 4];
    assign rf_we     = !Reset && (exec_write || state == ST_WB);
    assign alu_op    = opcode;
    assign alu_shamt = instr[SHAMT_LSB +: 5];
    assign alu_imm   = imm16;
    assign alu_a     = (state == ST_EXEC && is_alu) ? rf_rdata1 : '0;
    assign alu_b     = (state == ST_EXEC && is_alu) ? rf_rdata2 : '0;

    always_comb begin
        rf_wdata = '0;
        if (state == ST_WB)
            rf_wdata = load_data;
        else if (exec_write)
            rf_wdata = (opcode == OP_MOV) ? {{(DATA_W-16){1'b0}}, imm16} : alu_result;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            instr     <= '0;
            load_data <= '0;
            flags     <= '0;
            retired   <= '0;
            halted    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_req && mem_ack) begin
                        instr   <= mem_rdata[31:IMM_LSB];
                        pc      <= pc_inc;
                        mem_req <= 1'b0;
                        state   <= ST_DECODE;
                    end else if (!mem_req) begin
                        // Only reached straight out of reset; later fetches are armed on entry
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                ST_DECODE: begin
                    if (!cond_pass) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                        state    <= ST_FETCH;
                    end else if (opcode == OP_LDR || opcode == OP_STR) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (opcode == OP_STR);
                        mem_addr  <= rf_rdata1[ADDR_W-1:0];
                        mem_wdata <= rf_rdata2;
                        state     <= ST_MEM;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    retired <= retired + 32'd1;
                    if (is_alu && instr[S_BIT])
                        flags <= alu_flags;
                    if (opcode == OP_HLT) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= (opcode == OP_B) ? br_target : pc;
                        if (opcode == OP_B)
                            pc <= br_target;
                        state <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (mem_req && mem_ack) begin
                        if (mem_we) begin
                            retired  <= retired + 32'd1;
                            mem_we   <= 1'b0;
                            mem_addr <= pc;
                            state    <= ST_FETCH;
                        end else begin
                            load_data <= mem_rdata;
                            mem_req   <= 1'b0;
                            state     <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    retired  <= retired + 32'd1;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                    state    <= ST_FETCH;
                end
                ST_HALT: begin
                    halted <= 1'b1;
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [3:0]        rf_raddr1, rf_raddr2, rf_waddr;
    logic [DATA_W-1:0] rf_rdata1, rf_rdata2, rf_wdata;
    logic              rf_we;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [4:0]        alu_shamt;
    logic [15:0]       alu_imm;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        flags;
    logic              halted;
    logic [31:0]       retired;

    logic [31:0]       pmem [8];
    logic [31:0]       dmem [8:15];
    logic [31:0]       regs [16];
    int                wr_cyc [16];
    bit                regs_done = 1'b0;
    bit                ack_force = 1'b0;
    int                fetch_delay = 0;
    int                data_delay = 0;
    int                dly_v;
    int                wait_cnt = 0;
    int                cyc = 0;
    int                rf_writes = 0;
    int                wait_seen = 0;
    int                unstable = 0;
    bit                prev_wait = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic              prev_we;
    logic [DATA_W-1:0] prev_wdata;
    int                hs_cyc [$];
    logic [ADDR_W-1:0] hs_addr [$];
    logic              hs_we [$];
    int                checks = 0;
    int                failures = 0;

    cpu_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(4'd0)) dut (
        .Clk(Clk), .Reset(Reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_imm(alu_imm),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .pc(pc), .flags(flags), .halted(halted), .retired(retired)
    );

    always #5 Clk = ~Clk;

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    // External ALU: ADD, SUB, XOR for everything else; flags {N,Z,C,V}
    always_comb begin
        alu_result = '0;
        alu_flags  = '0;
        case (alu_op)
            4'h0: begin
                alu_result   = alu_a + alu_b;
                alu_flags[1] = ({1'b0, alu_a} + {1'b0, alu_b}) > 33'hFFFF_FFFF;
                alu_flags[0] = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            4'h1: begin
                alu_result   = alu_a - alu_b;
                alu_flags[1] = (alu_a >= alu_b);
                alu_flags[0] = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            default: alu_result = alu_a ^ alu_b;
        endcase
        alu_flags[3] = alu_result[31];
        alu_flags[2] = (alu_result == '0);
    end

    always @(negedge Clk) begin
        dly_v   = (mem_addr >= 4'd8) ? data_delay : fetch_delay;
        mem_ack = ack_force || (mem_req && wait_cnt >= dly_v);
        if (mem_ack)
            mem_rdata = (mem_addr >= 4'd8) ? dmem[mem_addr] : pmem[mem_addr[2:0]];
        else
            mem_rdata = '0;
    end

    always @(posedge Clk) begin
        if (!regs_done) begin
            for (int i = 0; i < 16; i++) begin
                regs[i]   = 32'hDEAD_0000 + 32'(i);
                wr_cyc[i] = -1;
            end
            regs_done = 1'b1;
        end
        if (Reset) begin
            cyc       = 0;
            wait_cnt  = 0;
            prev_wait = 1'b0;
            hs_cyc.delete();
            hs_addr.delete();
            hs_we.delete();
        end else begin
            cyc++;
            if (prev_wait && !(mem_req && mem_addr == prev_addr && mem_we == prev_we && mem_wdata == prev_wdata))
                unstable++;
            prev_wait  = mem_req && !mem_ack;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
            if (mem_req && mem_ack) begin
                hs_cyc.push_back(cyc);
                hs_addr.push_back(mem_addr);
                hs_we.push_back(mem_we);
                if (mem_we && mem_addr >= 4'd8)
                    dmem[mem_addr] = mem_wdata;
                wait_cnt = 0;
            end else if (mem_req) begin
                wait_cnt++;
                wait_seen++;
            end else begin
                wait_cnt = 0;
            end
        end
        if (rf_we) begin
            regs[rf_waddr]   = rf_wdata;
            wr_cyc[rf_waddr] = cyc;
            rf_writes++;
        end
    end

    function automatic logic [31:0] enc_r(input logic [3:0] cond, input logic [3:0] op, input logic s,
                                          input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        return {cond, op, s, rd, rs2, rs1, 5'd0, 6'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [3:0] cond, input logic [3:0] op,
                                          input logic [3:0] rd, input logic [15:0] imm);
        return {cond, op, 1'b0, rd, imm, 3'd0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc"}, 64'(pc), 64'd0);
        chk({tag, "_flags"}, 64'(flags), 64'd0);
        chk({tag, "_retired"}, 64'(retired), 64'd0);
        chk({tag, "_halted"}, 64'(halted), 64'd0);
        chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_rf_we"}, 64'(rf_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check_reset_state(tag);
        Reset = 1'b0;
    endtask

    localparam logic [3:0] AL = 4'hE, EQ = 4'h0, NE = 4'h1;

    initial begin
        int exp_cyc [10];
        int exp_adr [10];
        int exp_we  [10];
        int req_seen;
        int w0;

        exp_cyc = '{2, 5, 8, 11, 14, 16, 20, 21, 25, 27};
        exp_adr = '{0, 1, 2, 3, 4, 5, 10, 6, 10, 7};
        exp_we  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

        // Program A: MOVs, flag-setting SUB, conditional MOVs, STR/LDR with slow data ack, HLT
        pmem[0] = enc_i(AL, 4'hA, 4'd1, 16'd10);
        pmem[1] = enc_i(AL, 4'hA, 4'd2, 16'd10);
        pmem[2] = enc_r(AL, 4'h1, 1'b1, 4'd3, 4'd1, 4'd2);
        pmem[3] = enc_i(EQ, 4'hA, 4'd4, 16'd5);
        pmem[4] = enc_i(NE, 4'hA, 4'd5, 16'd7);
        pmem[5] = enc_r(AL, 4'hC, 1'b0, 4'd0, 4'd2, 4'd1);
        pmem[6] = enc_r(AL, 4'hB, 1'b0, 4'd6, 4'd2, 4'd0);
        pmem[7] = enc_r(AL, 4'hF, 1'b0, 4'd0, 4'd0, 4'd0);
        fetch_delay = 0;
        data_delay  = 2;
        do_reset("rst0");

        for (int i = 0; i < 200 && !halted; i++) @(negedge Clk);
        chk("a_halted", 64'(halted), 64'd1);
        chk("a_hs_count", 64'(hs_cyc.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("a_hs_cyc%0d", i), 64'(hs_cyc[i]), 64'(exp_cyc[i]));
            chk($sformatf("a_hs_addr%0d", i), 64'(hs_addr[i]), 64'(exp_adr[i]));
            chk($sformatf("a_hs_we%0d", i), 64'(hs_we[i]), 64'(exp_we[i]));
        end
        chk("a_r1", 64'(regs[1]), 64'd10);
        chk("a_r2", 64'(regs[2]), 64'd10);
        chk("a_r3", 64'(regs[3]), 64'd0);
        chk("a_r4", 64'(regs[4]), 64'd5);
        chk("a_r5_unwritten", 64'(regs[5]), 64'hDEAD_0005);
        chk("a_r6_load", 64'(regs[6]), 64'd10);
        chk("a_mem10", 64'(dmem[10]), 64'd10);
        chk("a_r1_wr_cyc", 64'(wr_cyc[1]), 64'd4);
        chk("a_r2_wr_cyc", 64'(wr_cyc[2]), 64'd7);
        chk("a_r6_wr_cyc", 64'(wr_cyc[6]), 64'd26);
        chk("a_rf_writes", 64'(rf_writes), 64'd5);
        chk("a_flags", 64'(flags), 64'b0110);
        chk("a_retired", 64'(retired), 64'd7);
        chk("a_pc", 64'(pc), 64'd8);
        chk("a_wait_cycles", 64'(wait_seen), 64'd4);
        chk("a_addr_stable", 64'(unstable), 64'd0);

        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (mem_req) req_seen++;
        end
        chk("halt_no_req", 64'(req_seen), 64'd0);
        chk("halt_sticky", 64'(halted), 64'd1);

        // Program B1: B +12 from address 3 wraps the 4-bit pc to 0; ack held high throughout
        for (int i = 0; i < 8; i++) pmem[i] = enc_r(AL, 4'hE, 1'b0, 4'd0, 4'd0, 4'd0);
        pmem[3]   = enc_i(AL, 4'hD, 4'd0, 16'h000C);
        ack_force = 1'b1;
        do_reset("rst_b1");
        for (int i = 0; i < 100 && hs_addr.size() < 5; i++) @(negedge Clk);
        chk("b1_hs_count", 64'(hs_addr.size() >= 5), 64'd1);
        chk("b1_ack_ignored", 64'(hs_cyc[0]), 64'd2);
        chk("b1_addr3", 64'(hs_addr[3]), 64'd3);
        chk("b1_wrap_addr", 64'(hs_addr[4]), 64'd0);
        chk("b1_wrap_cyc", 64'(hs_cyc[4]), 64'd14);

        // Program B2: B -1 at address 4 spins on itself
        pmem[3] = enc_r(AL, 4'hE, 1'b0, 4'd0, 4'd0, 4'd0);
        pmem[4] = enc_i(AL, 4'hD, 4'd0, 16'hFFFF);
        do_reset("rst_b2");
        for (int i = 0; i < 100 && hs_addr.size() < 8; i++) @(negedge Clk);
        chk("b2_hs_count", 64'(hs_addr.size() >= 8), 64'd1);
        for (int i = 4; i < 8; i++)
            chk($sformatf("b2_loop_addr%0d", i), 64'(hs_addr[i]), 64'd4);
        chk("b2_loop_period", 64'(hs_cyc[6] - hs_cyc[5]), 64'd3);

        // Program D: stall a fetch forever, then reset in the middle of it
        ack_force   = 1'b0;
        fetch_delay = 0;
        pmem[2]     = enc_i(AL, 4'hA, 4'd1, 16'd99);
        pmem[4]     = enc_r(AL, 4'hE, 1'b0, 4'd0, 4'd0, 4'd0);
        do_reset("rst_d");
        for (int i = 0; i < 50 && hs_addr.size() < 2; i++) @(negedge Clk);
        fetch_delay = 1000;
        for (int i = 0; i < 20 && !(mem_req && !mem_ack); i++) @(negedge Clk);
        chk("d_stalled_req", 64'(mem_req && !mem_ack), 64'd1);
        chk("d_stalled_pc", 64'(pc), 64'd2);
        chk("d_stalled_addr", 64'(mem_addr), 64'd2);
        w0 = rf_writes;
        Reset = 1'b1;
        @(negedge Clk);
        chk("d_rst_mem_req", 64'(mem_req), 64'd0);
        chk("d_rst_pc", 64'(pc), 64'd0);
        chk("d_rst_halted", 64'(halted), 64'd0);
        chk("d_rst_rf_we", 64'(rf_we), 64'd0);
        Reset = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("d_no_rf_write", 64'(rf_writes - w0), 64'd0);
        chk("d_r1_kept", 64'(regs[1]), 64'd10);
        chk("d_refetch_addr", 64'(mem_addr), 64'd0);
        fetch_delay = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
